// File: rtl/cs_frame_driver.sv
// rtl/cs_frame_driver.sv - buffers a host frame, plays it into CS, returns the CS results
// Clears CS before each frame, captures cs_y Y_LAT cycles behind cs_x, and unloads results over valid/ready.
module cs_frame_driver #(
  parameter int MAX_N = 64,
  parameter int WIN   = 9,
  parameter int Y_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] cs_x,
  output logic       cs_rst,
  input  logic [9:0] cs_y,
  output logic [9:0] res_data,
  output logic       res_valid,
  output logic       res_last,
  input  logic       res_ready,
  output logic       busy,
  output logic       frame_err
);

  localparam int CW = $clog2(MAX_N) + 1;
  localparam int AW = $clog2(MAX_N);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] WIN_C = CW'(WIN);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_N);
  localparam logic [CW-1:0] YL_C  = CW'(Y_LAT);
  localparam logic [CW-1:0] CAP0  = CW'(WIN - 1 + Y_LAT);

  typedef enum logic [2:0] {IDLE, LOAD, CLR, PLAY, FLUSH, UNLOAD} state_t;

  state_t        state;
  logic [7:0]    sbuf [MAX_N];
  logic [9:0]    rbuf [MAX_N];
  logic [CW-1:0] n, c, u;
  logic [CW-1:0] c_nxt, u_nxt;
  logic          s_we, r_we;
  logic [AW-1:0] s_addr, r_addr;

  assign c_nxt  = c + ONE;
  assign u_nxt  = u + ONE;
  assign s_we   = in_valid && in_ready && (state == IDLE || state == LOAD);
  assign s_addr = (state == IDLE) ? '0 : AW'(n);
  assign r_we   = (state == PLAY || state == FLUSH) && (c >= CAP0);
  assign r_addr = AW'(c - CAP0);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (s_we) sbuf[s_addr] <= in_data;
    if (r_we) rbuf[r_addr] <= cs_y;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cs_x      <= '0;
      cs_rst    <= 1'b1;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      res_data  <= '0;
      frame_err <= 1'b0;
      in_ready  <= 1'b0;
      n         <= '0;
      c         <= '0;
      u         <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cs_rst   <= 1'b0;
          cs_x     <= '0;
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            n <= ONE;
            if (in_last || MAX_C == ONE) begin
              state    <= CLR;
              in_ready <= 1'b0;
              cs_rst   <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            n <= n + ONE;
            // A full buffer ends the frame silently; the rest of the host's beats stay pending.
            if (in_last || (n + ONE) == MAX_C) begin
              state    <= CLR;
              in_ready <= 1'b0;
              cs_rst   <= 1'b1;
            end
          end
        end
        CLR: begin
          cs_rst <= 1'b0;
          c      <= '0;
          if (n < WIN_C) begin
            frame_err <= 1'b1;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            cs_x  <= sbuf[0];
            state <= PLAY;
          end
        end
        PLAY, FLUSH: begin
          c    <= c_nxt;
          cs_x <= (c_nxt < n) ? sbuf[AW'(c_nxt)] : 8'd0;
          if (c == n - ONE + YL_C) begin
            // The final result is written on this same edge; forward it when it is also the first.
            state     <= UNLOAD;
            res_valid <= 1'b1;
            res_data  <= (n == WIN_C) ? cs_y : rbuf[0];
            res_last  <= (n == WIN_C);
            u         <= '0;
          end else if (c == n - ONE) begin
            state <= FLUSH;
          end
        end
        UNLOAD: begin
          if (res_ready) begin
            if (res_last) begin
              res_valid <= 1'b0;
              res_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end else begin
              u        <= u_nxt;
              res_data <= rbuf[AW'(u_nxt)];
              res_last <= (u_nxt == n - WIN_C);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_frame_driver.sv
// tb/tb_cs_frame_driver.sv - self-checking bench for cs_frame_driver with a behavioural CS engine
// CS result for a window is the sum of its 9 samples shifted right by two.
module tb_cs_frame_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] cs_x;
  logic       cs_rst;
  logic [9:0] cs_y;
  logic [9:0] res_data;
  logic       res_valid;
  logic       res_last;
  logic       res_ready = 1'b0;
  logic       busy;
  logic       frame_err;

  cs_frame_driver #(.MAX_N(64), .WIN(9), .Y_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .cs_x(cs_x), .cs_rst(cs_rst), .cs_y(cs_y),
    .res_data(res_data), .res_valid(res_valid), .res_last(res_last), .res_ready(res_ready),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  logic [7:0] hist [0:8];
  always @(posedge clk) begin
    int s;
    if (cs_rst) begin
      for (int i = 0; i < 9; i++) hist[i] <= '0;
      cs_y <= '0;
    end else begin
      s = int'(cs_x);
      for (int i = 0; i < 8; i++) s += int'(hist[i]);
      for (int i = 8; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= cs_x;
      cs_y <= 10'(s >> 2);
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  logic [7:0] frame_q[$];
  int got_q[$], exp_q[$], play_q[$];
  int err_cnt, rst_cnt, acc_beats, last_idx, last_cnt, stable_bad, seen_valid, eff_len;
  bit exp_err, frame_done;

  task automatic run_frame(input int len, input bit no_last, input int vpct, input int rpct, input int hold);
    int idx = 0, cyc = 0, play_left = 0, post = 0, s;
    bit started = 0, acc_prev = 0, held_v = 0;
    logic [9:0] held = '0;
    eff_len = (len > 64) ? 64 : len;
    exp_q.delete(); got_q.delete(); play_q.delete();
    err_cnt = 0; rst_cnt = 0; last_idx = -1; last_cnt = 0; stable_bad = 0; seen_valid = 0;
    frame_done = 0;
    exp_err = (eff_len < 9);
    if (!exp_err)
      for (int j = 0; j <= eff_len - 9; j++) begin
        s = 0;
        for (int k = 0; k < 9; k++) s += int'(frame_q[j+k]);
        exp_q.push_back(s / 4);
      end
    while (!frame_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (frame_err) err_cnt++;
      if (play_left > 0) begin play_q.push_back(int'(cs_x)); play_left--; end
      if (cs_rst && idx > 0) begin
        rst_cnt++;
        if (!started) begin started = 1; play_left = eff_len; end
      end
      if (held_v && (!res_valid || res_data !== held)) stable_bad++;
      if (acc_prev) begin in_valid = 1'b0; in_last = 1'b0; end
      if (!in_valid && idx < len && $urandom_range(99) < vpct) begin
        in_valid = 1'b1;
        in_data  = frame_q[idx];
        in_last  = !no_last && (idx == len - 1);
      end
      acc_prev = in_valid && in_ready;
      if (acc_prev) idx++;
      if (res_valid) seen_valid++;
      res_ready = (seen_valid > hold) && ($urandom_range(99) < rpct);
      if (res_valid && res_ready) begin
        got_q.push_back(int'(res_data));
        if (res_last) begin last_idx = got_q.size() - 1; last_cnt++; frame_done = 1; end
        held_v = 0;
      end else if (res_valid) begin
        held_v = 1; held = res_data;
      end else held_v = 0;
      if (exp_err && err_cnt > 0) begin post++; if (post > 4) frame_done = 1; end
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b0;
    acc_beats = idx;
  endtask

  task automatic check_frame(input string nm);
    int mism = 0;
    chk({nm, ".done"}, int'(frame_done), 1);
    chk({nm, ".frame_err"}, err_cnt, int'(exp_err));
    chk({nm, ".cs_rst_cycles"}, rst_cnt, 1);
    chk({nm, ".beats"}, acc_beats, eff_len);
    if (!exp_err) begin
      chk({nm, ".nres"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        if (got_q[i] != exp_q[i]) mism++;
      chk({nm, ".res_mism"}, mism, 0);
      chk({nm, ".last_idx"}, last_idx, exp_q.size() - 1);
      chk({nm, ".last_cnt"}, last_cnt, 1);
      mism = 0;
      for (int i = 0; i < play_q.size() && i < eff_len; i++)
        if (play_q[i] != int'(frame_q[i])) mism++;
      chk({nm, ".play_len"}, play_q.size(), eff_len);
      chk({nm, ".play_mism"}, mism, 0);
      chk({nm, ".stable"}, stable_bad, 0);
    end else begin
      chk({nm, ".no_valid"}, seen_valid, 0);
    end
  endtask

  typedef struct {
    int len; int kind; int val; bit no_last;
    int exp_nres; int exp_first; int exp_lastv; bit exp_err;
  } vec_t;

  task automatic fill(input int len, input int kind, input int val);
    frame_q.delete();
    for (int i = 0; i < len; i++)
      frame_q.push_back((kind == 0) ? 8'(val) : (kind == 1) ? 8'(val + i) : 8'($urandom_range(255)));
  endtask

  initial begin
    vec_t vecs[7];
    int len;
    vecs[0] = '{9, 0, 90, 0, 1, 202, 202, 0};
    vecs[1] = '{10, 1, 1, 0, 2, 11, 13, 0};
    vecs[2] = '{5, 1, 1, 0, 0, 0, 0, 1};
    vecs[3] = '{10, 1, 1, 0, 2, 11, 13, 0};
    vecs[4] = '{70, 1, 1, 1, 56, 11, 135, 0};
    vecs[5] = '{9, 0, 255, 0, 1, 573, 573, 0};
    vecs[6] = '{8, 1, 1, 0, 0, 0, 0, 1};

    repeat (3) @(negedge clk);
    chk("rst.cs_rst", int'(cs_rst), 1);
    chk("rst.cs_x", int'(cs_x), 0);
    chk("rst.res_valid", int'(res_valid), 0);
    chk("rst.res_last", int'(res_last), 0);
    chk("rst.res_data", int'(res_data), 0);
    chk("rst.frame_err", int'(frame_err), 0);
    chk("rst.busy", int'(busy), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle.in_ready", int'(in_ready), 1);
    chk("idle.cs_rst", int'(cs_rst), 0);

    for (int v = 0; v < 7; v++) begin
      fill(vecs[v].len, vecs[v].kind, vecs[v].val);
      run_frame(vecs[v].len, vecs[v].no_last, 100, 100, 0);
      check_frame($sformatf("vec%0d", v));
      chk($sformatf("vec%0d.err_tbl", v), err_cnt, int'(vecs[v].exp_err));
      chk($sformatf("vec%0d.nres_tbl", v), got_q.size(), vecs[v].exp_nres);
      if (got_q.size() > 0) begin
        chk($sformatf("vec%0d.first", v), got_q[0], vecs[v].exp_first);
        chk($sformatf("vec%0d.lastv", v), got_q[got_q.size()-1], vecs[v].exp_lastv);
      end
      chk($sformatf("vec%0d.idle", v), int'(busy), 0);
    end

    fill(9, 1, 1);
    run_frame(9, 0, 100, 100, 20);
    check_frame("stall");
    chk("stall.valid_cycles", seen_valid, 21);
    if (got_q.size() > 0) chk("stall.value", got_q[0], 11);
    chk("stall.idle", int'(busy), 0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(i + 1); in_last = (i == 19);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort.in_play", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("abort.cs_rst", int'(cs_rst), 1);
    chk("abort.cs_x", int'(cs_x), 0);
    chk("abort.res_valid", int'(res_valid), 0);
    chk("abort.busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b1;
    fill(10, 1, 1);
    run_frame(10, 0, 100, 100, 0);
    check_frame("after_abort");
    if (got_q.size() == 2) begin
      chk("after_abort.r0", got_q[0], 11);
      chk("after_abort.r1", got_q[1], 13);
    end else chk("after_abort.nres", got_q.size(), 2);

    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, 75);
      fill(len, 2, 0);
      run_frame(len, len > 64, $urandom_range(30, 100), $urandom_range(20, 100), 0);
      check_frame($sformatf("rnd%0d", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
